// File: rtl/fib_seq_pkg.sv
// Shared encodings for the Fibonacci-style recurrence engine: ALU op codes and FSM states.
package fib_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD      = 2'b00,
        OP_SUB      = 2'b01,
        OP_XOR      = 2'b10,
        OP_ADD_HALT = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED0 = 3'd1,
        ST_SEED1 = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/fib_regfile.sv
// DEPTH x WIDTH register file: one synchronous write port, three combinational read ports,
// asynchronous active-low clear of every entry.
module fib_regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [AW-1:0]    raddr_disp,
    output logic [WIDTH-1:0] rdata_disp
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem[k] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a    = mem[raddr_a];
    assign rdata_b    = mem[raddr_b];
    assign rdata_disp = mem[raddr_disp];

endmodule

// File: rtl/fib_seq_engine.sv
// Two-seed recurrence engine: r[i] = f(r[i-2], r[i-1]) for len_eff terms, with flags,
// optional halt on carry and an independent display read port.
module fib_seq_engine
    import fib_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AW:0]      len,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic [AW:0]      term_count,
    output logic [WIDTH-1:0] last_value,
    output logic             carry_fl,
    output logic             zero_fl,
    output logic             neg_fl
);

    localparam logic [AW:0] LEN_MIN = (AW+1)'(2);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    state_e           state;
    op_e              op_lat;
    logic [AW:0]      len_lat;
    logic [WIDTH-1:0] seed_a_lat;
    logic [WIDTH-1:0] seed_b_lat;
    logic [AW-1:0]    idx;

    logic [AW:0]      len_eff;
    logic [AW:0]      idx_next;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             halt_now;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    fib_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr_a    (idx - AW'(2)),
        .rdata_a    (opnd_a),
        .raddr_b    (idx - AW'(1)),
        .rdata_b    (opnd_b),
        .raddr_disp (rd_addr),
        .rdata_disp (rd_data)
    );

    always_comb begin
        len_eff = len;
        if (len < LEN_MIN) begin
            len_eff = LEN_MIN;
        end else if (len > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
    end

    assign idx_next = {1'b0, idx} + (AW+1)'(1);

    // opnd_a = r[i-2], opnd_b = r[i-1]; SUB computes r[i-1] - r[i-2], MSB of diff is the borrow.
    always_comb begin
        sum    = {1'b0, opnd_b} + {1'b0, opnd_a};
        diff   = {1'b0, opnd_b} - {1'b0, opnd_a};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        unique case (op_lat)
            OP_ADD, OP_ADD_HALT: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            OP_XOR: begin
                result = opnd_a ^ opnd_b;
                carry  = 1'b0;
            end
        endcase
    end

    assign halt_now = (op_lat == OP_ADD_HALT) && carry;

    always_comb begin
        we    = 1'b0;
        waddr = idx;
        wdata = result;
        unique case (state)
            ST_SEED0: begin
                we    = 1'b1;
                waddr = '0;
                wdata = seed_a_lat;
            end
            ST_SEED1: begin
                we    = 1'b1;
                waddr = AW'(1);
                wdata = seed_b_lat;
            end
            ST_STEP: begin
                we = !halt_now;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_lat     <= OP_ADD;
            len_lat    <= '0;
            seed_a_lat <= '0;
            seed_b_lat <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            term_count <= '0;
            last_value <= '0;
            carry_fl   <= 1'b0;
            zero_fl    <= 1'b0;
            neg_fl     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_lat     <= op_e'(op);
                        len_lat    <= len_eff;
                        seed_a_lat <= seed_a;
                        seed_b_lat <= seed_b;
                        busy       <= 1'b1;
                        state      <= ST_SEED0;
                    end
                end
                ST_SEED0: begin
                    term_count <= (AW+1)'(1);
                    last_value <= seed_a_lat;
                    halted     <= 1'b0;
                    carry_fl   <= 1'b0;
                    zero_fl    <= 1'b0;
                    neg_fl     <= 1'b0;
                    state      <= ST_SEED1;
                end
                ST_SEED1: begin
                    term_count <= (AW+1)'(2);
                    last_value <= seed_b_lat;
                    idx        <= AW'(2);
                    if (len_lat > LEN_MIN) begin
                        state <= ST_STEP;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_STEP: begin
                    carry_fl <= carry;
                    zero_fl  <= (result == '0);
                    neg_fl   <= result[WIDTH-1];
                    if (halt_now) begin
                        halted <= 1'b1;
                        state  <= ST_DONE;
                        done   <= 1'b1;
                    end else begin
                        term_count <= idx_next;
                        last_value <= result;
                        idx        <= idx_next[AW-1:0];
                        if (idx_next >= len_lat) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Scoreboard bench: drivers push hand-computed expectations, a monitor checks them on each done pulse.
module tb_fib_seq_engine;

    localparam int AW = 4;

    typedef struct {
        string name;
        int    tc, lv, c, z, n, h, cyc;
        int    a0, v0, a1, v1;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q16[$];
    exp_t q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start16 = 1'b0, start8 = 1'b0;
    logic [1:0]    op16 = '0, op8 = '0;
    logic [AW:0]   len16 = '0, len8 = '0;
    logic [15:0]   sa16 = '0, sb16 = '0, rd16, lv16;
    logic [7:0]    sa8 = '0, sb8 = '0, rd8, lv8;
    logic [AW-1:0] ra16, ra8, drv_ra16 = '0, mon_ra16 = '0, mon_ra8 = '0;
    logic          mon_sel = 1'b0;
    logic          busy16, done16, halted16, c16, z16, n16;
    logic          busy8, done8, halted8, c8, z8, n8;
    logic [AW:0]   tc16, tc8;

    assign ra16 = mon_sel ? mon_ra16 : drv_ra16;
    assign ra8  = mon_ra8;

    fib_seq_engine #(.WIDTH(16), .DEPTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .len(len16),
        .seed_a(sa16), .seed_b(sb16), .rd_addr(ra16), .rd_data(rd16),
        .busy(busy16), .done(done16), .halted(halted16), .term_count(tc16),
        .last_value(lv16), .carry_fl(c16), .zero_fl(z16), .neg_fl(n16)
    );

    fib_seq_engine #(.WIDTH(8), .DEPTH(16)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .len(len8),
        .seed_a(sa8), .seed_b(sb8), .rd_addr(ra8), .rd_data(rd8),
        .busy(busy8), .done(done8), .halted(halted8), .term_count(tc8),
        .last_value(lv8), .carry_fl(c8), .zero_fl(z8), .neg_fl(n8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_result(input exp_t e, input logic [31:0] tc, input logic [31:0] lv,
                              input logic c, input logic z, input logic n, input logic h,
                              input logic b);
        chk({e.name, "/term_count"}, tc, e.tc);
        chk({e.name, "/last_value"}, lv, e.lv);
        chk({e.name, "/carry_fl"}, 32'(c), e.c);
        chk({e.name, "/zero_fl"}, 32'(z), e.z);
        chk({e.name, "/neg_fl"}, 32'(n), e.n);
        chk({e.name, "/halted"}, 32'(h), e.h);
        chk({e.name, "/busy_in_done"}, 32'(b), 1);
        chk({e.name, "/done_cycle"}, cyc, e.cyc);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation of that instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                if (q16.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL done16_unexpected: got a done pulse, required none");
                end else begin
                    e = q16.pop_front();
                    chk_result(e, 32'(tc16), 32'(lv16), c16, z16, n16, halted16, busy16);
                    mon_sel = 1'b1;
                    mon_ra16 = AW'(e.a0); #1;
                    chk({e.name, "/rd_a0"}, 32'(rd16), e.v0);
                    mon_ra16 = AW'(e.a1); #1;
                    chk({e.name, "/rd_a1"}, 32'(rd16), e.v1);
                    mon_sel = 1'b0;
                end
            end
            if (done8 === 1'b1) begin
                if (q8.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL done8_unexpected: got a done pulse, required none");
                end else begin
                    e = q8.pop_front();
                    chk_result(e, 32'(tc8), 32'(lv8), c8, z8, n8, halted8, busy8);
                    mon_ra8 = AW'(e.a0); #1;
                    chk({e.name, "/rd_a0"}, 32'(rd8), e.v0);
                    mon_ra8 = AW'(e.a1); #1;
                    chk({e.name, "/rd_a1"}, 32'(rd8), e.v1);
                end
            end
        end
    end

    task automatic wait_idle(input string nm, input bit wide);
        int n = 0;
        while (((wide ? busy16 : busy8) !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL %s/timeout: busy still high after 100 cycles, required low", nm);
        end
    endtask

    // hold > 1 keeps start asserted through the busy/DONE cycles to prove it is ignored.
    task automatic go16(input string nm, input logic [1:0] o, input int l, input int a, input int b,
                        input int hold, input int lat, input int tc, input int lv, input int c,
                        input int z, input int n, input int h, input int a0, input int v0,
                        input int a1, input int v1);
        exp_t e;
        @(negedge clk);
        start16 = 1'b1; op16 = o; len16 = (AW+1)'(l); sa16 = 16'(a); sb16 = 16'(b);
        e = '{nm, tc, lv, c, z, n, h, cyc + lat, a0, v0, a1, v1};
        q16.push_back(e);
        repeat (hold) @(negedge clk);
        start16 = 1'b0; op16 = ~o; len16 = '1; sa16 = 16'hDEAD; sb16 = 16'hBEEF;
        wait_idle(nm, 1'b1);
    endtask

    task automatic go8(input string nm, input logic [1:0] o, input int l, input int a, input int b,
                       input int lat, input int tc, input int lv, input int c, input int z,
                       input int n, input int h, input int a0, input int v0, input int a1,
                       input int v1);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1; op8 = o; len8 = (AW+1)'(l); sa8 = 8'(a); sb8 = 8'(b);
        e = '{nm, tc, lv, c, z, n, h, cyc + lat, a0, v0, a1, v1};
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0; op8 = ~o; len8 = '1; sa8 = 8'h5A; sb8 = 8'hA5;
        wait_idle(nm, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "/busy16"}, 32'(busy16), 0);
        chk({nm, "/done16"}, 32'(done16), 0);
        chk({nm, "/halted16"}, 32'(halted16), 0);
        chk({nm, "/tc16"}, 32'(tc16), 0);
        chk({nm, "/lv16"}, 32'(lv16), 0);
        chk({nm, "/flags16"}, 32'({c16, z16, n16}), 0);
        chk({nm, "/busy8"}, 32'(busy8), 0);
        chk({nm, "/tc8"}, 32'(tc8), 0);
        chk({nm, "/lv8"}, 32'(lv8), 0);
        chk({nm, "/flags8"}, 32'({c8, z8, n8, halted8}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        //    name        op    len a       b   hold lat tc  lv      c  z  n  h  a0  v0      a1 v1
        go16("fib16",     2'b00, 10, 0,      1,      1, 11, 10, 34,     0, 0, 0, 0, 9, 34,     0, 0);
        go16("sub16",     2'b01, 3,  5,      3,      1, 4,  3,  'hFFFE, 1, 0, 1, 0, 2, 'hFFFE, 0, 5);
        go16("xor16",     2'b10, 3,  'h1234, 'h1234, 1, 4,  3,  0,      0, 1, 0, 0, 2, 0,      0, 'h1234);
        go16("clamp_lo",  2'b00, 0,  7,      9,      4, 3,  2,  9,      0, 0, 0, 0, 1, 9,      0, 7);
        go16("clamp_hi",  2'b00, 31, 0,      1,      1, 17, 16, 610,    0, 0, 0, 0, 15, 610,   14, 377);
        go8("halt8",      2'b11, 16, 0,      1,         16, 14, 233,    1, 0, 0, 1, 13, 233,   14, 0);
        go8("wrap8",      2'b00, 16, 0,      1,         17, 16, 98,     1, 0, 0, 0, 14, 121,   15, 98);

        // Abort a run in STEP with reset; no done pulse may follow.
        @(negedge clk);
        start16 = 1'b1; op16 = 2'b00; len16 = 5'd16; sa16 = 16'd0; sb16 = 16'd1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int k = 0; k < 16; k++) begin
            drv_ra16 = AW'(k);
            #1;
            chk($sformatf("abort/rd16[%0d]", k), 32'(rd16), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        go16("fib16_after_reset", 2'b00, 10, 0, 1, 1, 11, 10, 34, 0, 0, 0, 0, 9, 34, 8, 21);

        repeat (3) @(negedge clk);
        chk("pending16", q16.size(), 0);
        chk("pending8", q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
